// File: rtl/cache_arbiter.sv
// Two-way arbiter sharing one cacheline adaptor between the I-cache and D-cache.
// Ports: clk/rst; i_* I-cache read side; d_* D-cache read/writeback side; mem_* adaptor side.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        RELEASE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(5'h1f);

    state_t                  state, state_nx;
    logic                    last_grant, last_grant_nx;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nx;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_nx;
    logic                    write_q, write_nx;
    logic                    i_pend, d_pend, pick_d, busy;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;
    // last_grant = 1 means D won last time, so a tie goes to I.
    assign pick_d = d_pend & (~i_pend | ~last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            addr_q     <= addr_nx;
            wdata_q    <= wdata_nx;
            write_q    <= write_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        addr_nx       = addr_q;
        wdata_nx      = wdata_q;
        write_nx      = write_q;
        unique case (state)
            IDLE: begin
                if (i_pend | d_pend) begin
                    last_grant_nx = pick_d;
                    if (pick_d) begin
                        state_nx = D_BUSY;
                        addr_nx  = d_address & LINE_MASK;
                        // Writeback wins when read and write arrive together.
                        write_nx = d_write;
                        wdata_nx = d_wdata;
                    end else begin
                        state_nx = I_BUSY;
                        addr_nx  = i_address & LINE_MASK;
                        write_nx = 1'b0;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) state_nx = RELEASE;
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy        = (state == I_BUSY) || (state == D_BUSY);
    assign mem_read    = busy & ~write_q;
    assign mem_write   = busy & write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign i_resp  = (state == I_BUSY) & mem_resp;
    assign d_resp  = (state == D_BUSY) & mem_resp;

endmodule
